dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU load/store path and a DMA master (the UART loader or a future block-copy engine).
- The CPU has priority by default, so the pipeline stalls only when it must.
- The DMA master receives locked bursts, bounded in length and protected against starvation.
- Sits between the bus address decode (CPU side arrives already decoded to the data-memory range) and the DataMemory instance: synchronous write, combinational read.

Parameters:
ADDR_BIT, 8, word-address width of the data memory
MAX_BURST, 16, maximum DMA beats per grant before the port returns to the CPU (>=1)
STARVE_LIMIT, 4, consecutive cycles a pending DMA request may be refused before it pre-empts the CPU (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
cpu_req  input  1  CPU access to data-memory range this cycle
cpu_we  input  1  CPU access is a write
cpu_addr  input  32  CPU byte address; word index = cpu_addr[ADDR_BIT+1:2]
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  read data, valid in the cycle the CPU is served
cpu_stall  output  1  CPU request not served this cycle; hold request
dma_req  input  1  DMA beat pending
dma_we  input  1  DMA beat is a write
dma_addr  input  ADDR_BIT  DMA word address
dma_wdata  input  32  DMA write data
dma_last  input  1  current beat is the final beat of the burst
dma_gnt  output  1  DMA beat accepted this cycle
dma_rvalid  output  1  registered DMA read data valid (one cycle after granted read)
dma_rdata  output  32  registered DMA read data
mem_we  output  1  to DataMemory write enable
mem_addr  output  ADDR_BIT  to DataMemory word address
mem_wdata  output  32  to DataMemory write data
mem_rdata  input  32  from DataMemory combinational read
busy  output  1  DMA owns the port (state S_DMA)

Behaviour:
- States: S_CPU (reset state) and S_DMA. Registers: state, beat_cnt (0..MAX_BURST), starve_cnt (0..STARVE_LIMIT, saturating), dma_rvalid, dma_rdata.
- Reset (reset==0 at a clock edge): state=S_CPU, beat_cnt=0, starve_cnt=0, dma_rvalid=0, dma_rdata=0.
- While reset==0, combinational outputs are forced: mem_we=0, dma_gnt=0, cpu_stall=0, cpu_rdata=0.
- Owner each cycle (combinational):
  - S_CPU: DMA is served iff dma_req && (!cpu_req || starve_cnt==STARVE_LIMIT); otherwise the CPU is served if cpu_req.
  - S_DMA with dma_req: DMA is served.
  - S_DMA with !dma_req: CPU is served if cpu_req (burst abandoned).
- When CPU is served:
  - Memory outputs: mem_addr=cpu_addr[ADDR_BIT+1:2], mem_we=cpu_we, mem_wdata=cpu_wdata.
  - Handshake: cpu_rdata=mem_rdata, cpu_stall=0, dma_gnt=0.
- When DMA is served:
  - Memory outputs: mem_addr=dma_addr, mem_we=dma_we, mem_wdata=dma_wdata.
  - Handshake: dma_gnt=1, cpu_stall=cpu_req, cpu_rdata=0.
- When idle: mem_we=0, mem_addr=0, cpu_stall=0, dma_gnt=0.
- cpu_stall never asserts without cpu_req. mem_we never asserts without a served requester.
- starve_cnt:
  - Increments (saturating) in S_CPU when dma_req is refused.
  - Clears on any DMA grant, and when dma_req is low.
- Transitions:
  - S_CPU, DMA granted, !dma_last and MAX_BURST>1 -> S_DMA, beat_cnt=1.
  - S_CPU, DMA granted with dma_last (or MAX_BURST==1) -> stays S_CPU; single-beat burst.
  - S_DMA, granted beat with dma_last, or beat_cnt+1==MAX_BURST -> S_CPU, beat_cnt=0. A CPU request pending at that edge is served next cycle.
  - S_DMA, !dma_req -> S_CPU, beat_cnt=0.
  - Otherwise S_DMA, beat_cnt+1.
- A burst truncated by MAX_BURST re-arbitrates: the DMA master keeps dma_req high and is re-granted under the S_CPU rules.
- DMA read: on a granted beat with !dma_we, dma_rdata<=mem_rdata and dma_rvalid<=1 at the next edge. dma_rvalid is 0 otherwise (single-cycle pulse per beat; back-to-back reads give continuous valid).
- Simultaneous first requests in S_CPU with starve_cnt<STARVE_LIMIT: CPU wins.
- Reset asserted mid-burst: burst dropped, state S_CPU next cycle, no pending dma_rvalid.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF, then a read of 0x10 -> mem_we=1, mem_addr=4; read gives cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- DMA burst, CPU idle: 4 write beats to addr 0..3, dma_last on beat 4 -> dma_gnt=1 for 4 cycles, busy=1 for cycles 2-4, back to S_CPU after beat 4.
- Contention: cpu_req and dma_req held high continuously, STARVE_LIMIT=4, MAX_BURST=16, dma_last never -> CPU served cycles 0-3, DMA granted cycle 4, then 15 more DMA beats (cpu_stall=1 for 16 cycles), then CPU served again.
- DMA read latency: granted read of addr 7 holding 0x12345678 -> next cycle dma_rvalid=1, dma_rdata=0x12345678; following idle cycle dma_rvalid=0.
- Burst abandon: in S_DMA drop dma_req while cpu_req=1 -> same cycle cpu_stall=0 and CPU served; next cycle busy=0.
- Reset mid-burst: reset=0 during beat 3 -> mem_we=0, dma_gnt=0 that cycle; after release state S_CPU, beat_cnt=0, dma_rvalid=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU load/store path
// and a DMA master. The CPU has priority; DMA gets bounded locked bursts and
// pre-empts the CPU after STARVE_LIMIT consecutive refusals.
module dmem_arbiter #(
    parameter int unsigned ADDR_BIT     = 8,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_stall,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_BIT-1:0] dma_addr,
    input  logic [31:0]         dma_wdata,
    input  logic                dma_last,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [31:0]         dma_rdata,
    output logic                mem_we,
    output logic [ADDR_BIT-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                busy
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            dma_serve_c;
    logic            cpu_serve_c;
    logic            burst_end_c;
    logic            unused_addr_bits;

    // Byte-offset and upper address bits are decoded upstream.
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_BIT+2], cpu_addr[1:0]};

    assign busy = (state == S_DMA);

    // Decide who owns the port this cycle; nobody while reset is held.
    always_comb begin
        dma_serve_c = 1'b0;
        cpu_serve_c = 1'b0;
        if (reset) begin
            if (state == S_CPU) begin
                dma_serve_c = dma_req && (!cpu_req || (starve_cnt == SW'(STARVE_LIMIT)));
            end else begin
                dma_serve_c = dma_req;
            end
            cpu_serve_c = cpu_req && !dma_serve_c;
        end
    end

    // Steer the memory port and the requester handshakes from the owner.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        dma_gnt   = 1'b0;
        if (dma_serve_c) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            dma_gnt   = 1'b1;
            cpu_stall = cpu_req;
        end else if (cpu_serve_c) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[ADDR_BIT+1:2];
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end
    end

    // A granted beat in S_DMA closes the burst on dma_last or the beat cap.
    assign burst_end_c = dma_last || ((beat_cnt + BW'(1)) == BW'(MAX_BURST));

    // Burst state, beat/starvation counters and registered DMA read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_CPU;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_serve_c && !dma_we;
            if (dma_serve_c && !dma_we) begin
                dma_rdata <= mem_rdata;
            end

            if (!dma_req || dma_serve_c) begin
                starve_cnt <= '0;
            end else if ((state == S_CPU) && (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                S_CPU: begin
                    if (dma_serve_c && !dma_last && (MAX_BURST > 1)) begin
                        state    <= S_DMA;
                        beat_cnt <= BW'(1);
                    end
                end
                S_DMA: begin
                    if (!dma_req || burst_end_c) begin
                        state    <= S_CPU;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    state    <= S_CPU;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory model.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_BIT = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                cpu_req, cpu_we;
    logic [31:0]         cpu_addr, cpu_wdata, cpu_rdata;
    logic                cpu_stall;
    logic                dma_req, dma_we, dma_last;
    logic [ADDR_BIT-1:0] dma_addr;
    logic [31:0]         dma_wdata;
    logic                dma_gnt, dma_rvalid;
    logic [31:0]         dma_rdata;
    logic                mem_we;
    logic [ADDR_BIT-1:0] mem_addr;
    logic [31:0]         mem_wdata, mem_rdata;
    logic                busy;

    logic [31:0] mem [0:(1<<ADDR_BIT)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_BIT(ADDR_BIT), .MAX_BURST(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // DataMemory: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_last = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_BIT); i++) mem[i] = 32'h0;
        idle_inputs();
        reset = 0;
        tick(); tick();

        // Reset: outputs forced even with both requesters active.
        cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1;
        settle();
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check_val("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rvalid", 32'(dma_rvalid), 32'd0);
        check_val("rst_rdata", dma_rdata, 32'd0);
        tick();
        idle_inputs();
        reset = 1;
        tick();

        // CPU only: write then read back.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        settle();
        check_val("cpu_wr_we", 32'(mem_we), 32'd1);
        check_val("cpu_wr_addr", 32'(mem_addr), 32'd4);
        check_val("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_we = 0;
        settle();
        check_val("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        check_val("cpu_rd_we", 32'(mem_we), 32'd0);
        check_val("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        tick();
        // Preload word 7 for the DMA read test.
        cpu_we = 1; cpu_addr = 32'h1C; cpu_wdata = 32'h12345678;
        tick();
        idle_inputs();

        // DMA 4-beat write burst, CPU idle.
        for (int i = 0; i < 4; i++) begin
            dma_req = 1; dma_we = 1; dma_addr = 8'(i); dma_wdata = 32'hA0 + 32'(i);
            dma_last = (i == 3);
            settle();
            check_val($sformatf("burst_gnt%0d", i), 32'(dma_gnt), 32'd1);
            check_val($sformatf("burst_busy%0d", i), 32'(busy), 32'(i > 0));
            check_val($sformatf("burst_addr%0d", i), 32'(mem_addr), 32'(i));
            tick();
        end
        idle_inputs();
        settle();
        check_val("burst_done_busy", 32'(busy), 32'd0);
        cpu_req = 1; cpu_addr = 32'h8;
        settle();
        check_val("burst_mem2", cpu_rdata, 32'hA2);
        tick();
        idle_inputs();

        // DMA single-beat read of word 7.
        dma_req = 1; dma_we = 0; dma_addr = 8'd7; dma_last = 1;
        settle();
        check_val("dmard_gnt", 32'(dma_gnt), 32'd1);
        tick();
        idle_inputs();
        settle();
        check_val("dmard_rvalid", 32'(dma_rvalid), 32'd1);
        check_val("dmard_rdata", dma_rdata, 32'h12345678);
        check_val("dmard_busy", 32'(busy), 32'd0);
        tick();
        check_val("dmard_rvalid_off", 32'(dma_rvalid), 32'd0);

        // Contention: both held high, no dma_last.
        for (int c = 0; c < 24; c++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
            dma_req = 1; dma_we = 1; dma_addr = 8'(8'h20 + c); dma_wdata = 32'(c); dma_last = 0;
            settle();
            check_val($sformatf("cont_gnt%0d", c), 32'(dma_gnt), 32'(c >= 4 && c < 20));
            check_val($sformatf("cont_stall%0d", c), 32'(cpu_stall), 32'(c >= 4 && c < 20));
            check_val($sformatf("cont_busy%0d", c), 32'(busy), 32'(c >= 5 && c < 20));
            tick();
        end
        idle_inputs();
        tick();

        // Burst abandon: drop dma_req in S_DMA while the CPU requests.
        dma_req = 1; dma_we = 1; dma_addr = 8'h30; dma_last = 0;
        tick();
        dma_addr = 8'h31;
        tick();
        dma_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
        settle();
        check_val("abn_busy_before", 32'(busy), 32'd1);
        check_val("abn_stall", 32'(cpu_stall), 32'd0);
        check_val("abn_gnt", 32'(dma_gnt), 32'd0);
        check_val("abn_mem_addr", 32'(mem_addr), 32'h10);
        check_val("abn_mem_we", 32'(mem_we), 32'd1);
        tick();
        cpu_we = 0;
        settle();
        check_val("abn_busy_after", 32'(busy), 32'd0);
        check_val("abn_rdback", cpu_rdata, 32'h55);
        tick();
        idle_inputs();

        // Reset asserted during beat 3 of a read burst.
        dma_req = 1; dma_we = 0; dma_addr = 8'd0; dma_last = 0;
        tick();
        dma_addr = 8'd1;
        tick();
        dma_addr = 8'd2; dma_we = 1; cpu_req = 1;
        reset = 0;
        settle();
        check_val("rmb_mem_we", 32'(mem_we), 32'd0);
        check_val("rmb_gnt", 32'(dma_gnt), 32'd0);
        check_val("rmb_stall", 32'(cpu_stall), 32'd0);
        check_val("rmb_cpu_rdata", cpu_rdata, 32'd0);
        check_val("rmb_rvalid_prev", 32'(dma_rvalid), 32'd1);
        tick();
        reset = 1;
        idle_inputs();
        settle();
        check_val("rmb_busy", 32'(busy), 32'd0);
        check_val("rmb_rvalid", 32'(dma_rvalid), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
